// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD init sequencer: ROM entry layout, entry types and FSM states.
package lcd_pkg;

  localparam int ENTRY_W = 10;

  localparam logic [1:0] ENT_CMD = 2'b00;
  localparam logic [1:0] ENT_DAT = 2'b01;
  localparam logic [1:0] ENT_DLY = 2'b10;
  localparam logic [1:0] ENT_END = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LO,
    ST_RST_HI,
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_DELAY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lcd_init_rom.sv
// Synchronous-read script ROM; the panel script lives entirely in ROM_INIT (entry i at bits
// [i*ENTRY_W +: ENTRY_W]) so a different panel only needs a different parameter value.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int                           ROM_DEPTH = 64,
  parameter int                           ADDR_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1,
  parameter logic [ROM_DEPTH*ENTRY_W-1:0] ROM_INIT  = '1
) (
  input  logic               clk,
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] entry
);

  logic [ENTRY_W-1:0] entry_d;
  logic [ENTRY_W-1:0] entry_q;

  always_comb begin
    entry_d = ROM_INIT[int'(addr)*ENTRY_W +: ENTRY_W];
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/lcd_init_seq.sv
// LCD init sequencer: pulses the panel reset, then walks the script ROM and hands command/data
// bytes to the serial shifter over a valid/ready handshake.
module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter int                           TICKS_PER_MS = 27000,
  parameter int                           ROM_DEPTH    = 64,
  parameter int                           RST_LOW_MS   = 10,
  parameter int                           RST_REL_MS   = 120,
  parameter logic [ROM_DEPTH*ENTRY_W-1:0] ROM_INIT     = '1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tx_rdy,
  output logic       tx_vld,
  output logic [7:0] tx_byte,
  output logic       tx_dc,
  output logic       lcd_rst_n,
  output logic       busy,
  output logic       done
);

  localparam int ADDR_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICKS_PER_MS - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST    = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [7:0]        RST_LO_LAST = 8'(RST_LOW_MS - 1);
  localparam logic [7:0]        RST_HI_LAST = 8'(RST_REL_MS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [7:0]          ms_q, ms_d;
  logic                tx_vld_q, tx_vld_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                tx_dc_q, tx_dc_d;
  logic                lcd_rst_n_q, lcd_rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ENTRY_W-1:0]  entry;
  logic [1:0]          ent_type;
  logic [7:0]          ent_payload;
  logic [7:0]          ms_last;
  logic                timed;
  logic                timer_done;
  logic                advance;

  lcd_init_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .ADDR_W    (ADDR_W),
    .ROM_INIT  (ROM_INIT)
  ) u_rom (
    .clk   (clk),
    .addr  (ptr_q),
    .entry (entry)
  );

  assign ent_type    = entry[ENTRY_W-1 -: 2];
  assign ent_payload = entry[7:0];

  // Terminal-count compare: the state ends on the cycle where tick and ms both hit their last value.
  always_comb begin
    ms_last = 8'd0;
    timed   = 1'b0;
    case (state_q)
      ST_RST_LO: begin ms_last = RST_LO_LAST;        timed = 1'b1; end
      ST_RST_HI: begin ms_last = RST_HI_LAST;        timed = 1'b1; end
      ST_DELAY:  begin ms_last = ent_payload - 8'd1; timed = 1'b1; end
      default:   ;
    endcase
    timer_done = timed && (tick_q == TICK_LAST) && (ms_q == ms_last);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tx_byte_d = tx_byte_q;
    tx_dc_d   = tx_dc_q;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RST_LO;
          ptr_d   = '0;
        end
      end
      ST_RST_LO: if (timer_done) state_d = ST_RST_HI;
      ST_RST_HI: if (timer_done) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (ent_type)
          ENT_CMD, ENT_DAT: begin
            tx_byte_d = ent_payload;
            tx_dc_d   = (ent_type == ENT_DAT);
            state_d   = ST_SEND;
          end
          ENT_DLY: begin
            if (ent_payload == 8'd0) advance = 1'b1;
            else                     state_d = ST_DELAY;
          end
          default: state_d = ST_DONE;
        endcase
      end
      ST_SEND:  if (tx_rdy) advance = 1'b1;
      ST_DELAY: if (timer_done) advance = 1'b1;
      default:  state_d = ST_IDLE;
    endcase

    // Consuming the last ROM slot ends the script rather than wrapping back to entry 0.
    if (advance) begin
      if (ptr_q == PTR_LAST) begin
        state_d = ST_DONE;
      end else begin
        ptr_d   = ptr_q + 1'b1;
        state_d = ST_FETCH;
      end
    end
  end

  always_comb begin
    tick_d = '0;
    ms_d   = 8'd0;
    if (timed && (state_d == state_q)) begin
      if (tick_q == TICK_LAST) begin
        ms_d = ms_q + 8'd1;
      end else begin
        tick_d = tick_q + 1'b1;
        ms_d   = ms_q;
      end
    end
  end

  always_comb begin
    tx_vld_d    = (state_d == ST_SEND);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
    lcd_rst_n_d = lcd_rst_n_q;
    if (state_d == ST_RST_LO)      lcd_rst_n_d = 1'b0;
    else if (state_d == ST_RST_HI) lcd_rst_n_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      tick_q      <= '0;
      ms_q        <= 8'd0;
      tx_vld_q    <= 1'b0;
      tx_byte_q   <= 8'd0;
      tx_dc_q     <= 1'b0;
      lcd_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tick_q      <= tick_d;
      ms_q        <= ms_d;
      tx_vld_q    <= tx_vld_d;
      tx_byte_q   <= tx_byte_d;
      tx_dc_q     <= tx_dc_d;
      lcd_rst_n_q <= lcd_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_vld    = tx_vld_q;
  assign tx_byte   = tx_byte_q;
  assign tx_dc     = tx_dc_q;
  assign lcd_rst_n = lcd_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Bench for lcd_init_seq: three instances with different scripts, a transfer scoreboard and a
// window-indexed vector table for the reset/start timeline.
module tb_lcd_init_seq;
  import lcd_pkg::*;

  localparam int TPM    = 4;
  localparam int LOW_MS = 2;
  localparam int REL_MS = 3;
  localparam int LO_CYC = LOW_MS * TPM;
  localparam int HI_CYC = REL_MS * TPM;
  localparam int FETCH0 = LO_CYC + HI_CYC + 1;

  // Entries are {type, payload}; entry 0 is the rightmost field.
  localparam logic [79:0] ROM_A = {{6{10'h300}}, 10'h1A5, 10'h011};
  localparam logic [79:0] ROM_B = {{4{10'h300}}, 10'h029, 10'h200, 10'h205, 10'h001};
  localparam logic [39:0] ROM_D = {10'h15A, 10'h201, 10'h13C, 10'h02A};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       start [3];
  logic       tx_rdy [3];
  logic       tx_vld [3];
  logic [7:0] tx_byte [3];
  logic       tx_dc [3];
  logic       lcd_rst_n [3];
  logic       busy [3];
  logic       done [3];

  lcd_init_seq #(.TICKS_PER_MS(TPM), .ROM_DEPTH(8), .RST_LOW_MS(LOW_MS), .RST_REL_MS(REL_MS),
                 .ROM_INIT(ROM_A)) u_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .tx_rdy(tx_rdy[0]), .tx_vld(tx_vld[0]),
    .tx_byte(tx_byte[0]), .tx_dc(tx_dc[0]), .lcd_rst_n(lcd_rst_n[0]), .busy(busy[0]), .done(done[0]));

  lcd_init_seq #(.TICKS_PER_MS(TPM), .ROM_DEPTH(8), .RST_LOW_MS(LOW_MS), .RST_REL_MS(REL_MS),
                 .ROM_INIT(ROM_B)) u_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .tx_rdy(tx_rdy[1]), .tx_vld(tx_vld[1]),
    .tx_byte(tx_byte[1]), .tx_dc(tx_dc[1]), .lcd_rst_n(lcd_rst_n[1]), .busy(busy[1]), .done(done[1]));

  lcd_init_seq #(.TICKS_PER_MS(TPM), .ROM_DEPTH(4), .RST_LOW_MS(LOW_MS), .RST_REL_MS(REL_MS),
                 .ROM_INIT(ROM_D)) u_d (
    .clk(clk), .rst(rst[2]), .start(start[2]), .tx_rdy(tx_rdy[2]), .tx_vld(tx_vld[2]),
    .tx_byte(tx_byte[2]), .tx_dc(tx_dc[2]), .lcd_rst_n(lcd_rst_n[2]), .busy(busy[2]), .done(done[2]));

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       dc;
  } xfer_t;

  typedef struct {
    int         win;
    logic       busy;
    logic       rstn;
    logic       vld;
    logic       done;
    logic       chk_data;
    logic [7:0] data;
    logic       dc;
  } vec_t;

  xfer_t    exp_q[$];
  int       xfer_cyc[$];
  vec_t     vecs[$];
  int       cyc = 0;
  int       n_checks = 0;
  int       n_pass = 0;
  bit [2:0] prev_xfer = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int w, logic b, logic r, logic v, logic d, logic c,
                              logic [7:0] dt, logic dcv);
    vec_t x;
    x.win = w; x.busy = b; x.rstn = r; x.vld = v; x.done = d;
    x.chk_data = c; x.data = dt; x.dc = dcv;
    return x;
  endfunction

  // Scoreboard: every accepted byte must match the front of the expectation queue.
  always @(negedge clk) begin : monitor
    xfer_t x;
    for (int i = 0; i < 3; i++) begin
      if (prev_xfer[i]) check($sformatf("vld_after_xfer%0d", i), tx_vld[i], 1'b0);
      prev_xfer[i] = tx_vld[i] && tx_rdy[i] && rst[i];
      if (tx_vld[i] && tx_rdy[i]) begin
        check("xfer_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          x = exp_q.pop_front();
          check("xfer_inst", i, x.inst);
          check("xfer_byte", tx_byte[i], x.data);
          check("xfer_dc", tx_dc[i], x.dc);
          xfer_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   win;
    int   k;
    int   gap;
    int   exp_gap;
    int   dly_ms[2];
    vec_t v;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; start[i] = 1'b0; tx_rdy[i] = 1'b0;
    end
    tx_rdy[0] = 1'b1;

    // Timeline of instance A measured in cycles after start is sampled.
    vecs.push_back(mk(0,            0, 0, 0, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1,            1, 0, 0, 0, 1, 8'h00, 0));
    vecs.push_back(mk(LO_CYC,       1, 0, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(LO_CYC + 1,   1, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(FETCH0 - 1,   1, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(FETCH0 + 1,   1, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(FETCH0 + 2,   1, 1, 1, 0, 1, 8'h11, 0));
    vecs.push_back(mk(FETCH0 + 3,   1, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(FETCH0 + 5,   1, 1, 1, 0, 1, 8'hA5, 1));
    vecs.push_back(mk(FETCH0 + 7,   1, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(FETCH0 + 8,   0, 1, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(FETCH0 + 14,  0, 1, 0, 1, 0, 8'h00, 0));

    repeat (3) step();
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_state%0d", i),
            {tx_vld[i], tx_byte[i], tx_dc[i], lcd_rst_n[i], busy[i], done[i]}, '0);

    // Reset timing and a two-byte script.
    rst[0] = 1'b1;
    step();
    exp_q.push_back('{0, 8'h11, 1'b0});
    exp_q.push_back('{0, 8'hA5, 1'b1});
    win = 0;
    start[0] = 1'b1;
    foreach (vecs[n]) begin
      v = vecs[n];
      while (win < v.win) begin
        step();
        win++;
        start[0] = 1'b0;
      end
      if (v.chk_data)
        check($sformatf("vec_w%0d", v.win),
              {busy[0], lcd_rst_n[0], tx_vld[0], done[0], tx_byte[0], tx_dc[0]},
              {v.busy, v.rstn, v.vld, v.done, v.data, v.dc});
      else
        check($sformatf("vec_w%0d", v.win),
              {busy[0], lcd_rst_n[0], tx_vld[0], done[0]}, {v.busy, v.rstn, v.vld, v.done});
    end
    check("a_queue_drained", exp_q.size(), 0);

    // Replay from DONE, stall in SEND, ignored start, then asynchronous abort.
    tx_rdy[0] = 1'b0;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check("replay_rst_lo", {busy[0], lcd_rst_n[0], done[0]}, 3'b100);
    k = 0;
    while (!tx_vld[0] && k < 100) begin
      step();
      k++;
    end
    check("replay_send_latency", k, LO_CYC + HI_CYC + 2);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check("start_ignored_send", {busy[0], tx_vld[0], tx_byte[0], tx_dc[0]}, {1'b1, 1'b1, 8'h11, 1'b0});
    repeat (3) step();
    check("send_still_held", {busy[0], tx_vld[0], tx_byte[0]}, {1'b1, 1'b1, 8'h11});
    rst[0] = 1'b0;
    #1;
    check("async_abort", {tx_vld[0], lcd_rst_n[0], busy[0], done[0]}, 4'b0000);
    step();
    rst[0] = 1'b1;
    step();
    tx_rdy[0] = 1'b1;
    exp_q.push_back('{0, 8'h11, 1'b0});
    exp_q.push_back('{0, 8'hA5, 1'b1});
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    k = 0;
    while (!done[0] && k < 200) begin
      step();
      k++;
    end
    check("rerun_done_latency", k, FETCH0 + 7);
    check("rerun_done_state", {done[0], busy[0]}, 2'b10);
    check("rerun_queue_drained", exp_q.size(), 0);

    // Delay entries: DLY 5 costs its ms plus a fetch/decode, DLY 0 only the fetch/decode.
    rst[1] = 1'b1;
    tx_rdy[1] = 1'b1;
    step();
    xfer_cyc.delete();
    exp_q.push_back('{1, 8'h01, 1'b0});
    exp_q.push_back('{1, 8'h29, 1'b0});
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    k = 0;
    while (!done[1] && k < 300) begin
      step();
      k++;
    end
    check("b_done", {done[1], busy[1]}, 2'b10);
    check("b_xfer_count", xfer_cyc.size(), 2);
    dly_ms = '{5, 0};
    exp_gap = 3;
    foreach (dly_ms[n]) exp_gap += 2 + dly_ms[n] * TPM;
    gap = (xfer_cyc.size() >= 2) ? (xfer_cyc[1] - xfer_cyc[0]) : -1;
    check("b_xfer_spacing", gap, exp_gap);

    // Downstream stall, then a 4-entry ROM with no END entry.
    rst[2] = 1'b1;
    step();
    exp_q.push_back('{2, 8'h2A, 1'b0});
    exp_q.push_back('{2, 8'h3C, 1'b1});
    exp_q.push_back('{2, 8'h5A, 1'b1});
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    k = 0;
    while (!tx_vld[2] && k < 100) begin
      step();
      k++;
    end
    check("d_reaches_send", tx_vld[2], 1'b1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall_hold%0d", i), {tx_vld[2], tx_byte[2], tx_dc[2]}, {1'b1, 8'h2A, 1'b0});
      step();
    end
    tx_rdy[2] = 1'b1;
    k = 0;
    while (!done[2] && k < 200) begin
      step();
      k++;
    end
    check("d_wrap_done", {done[2], busy[2]}, 2'b10);
    check("d_queue_drained", exp_q.size(), 0);
    repeat (10) step();
    check("d_no_resend", {done[2], busy[2], tx_vld[2]}, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
